// File: rtl/cpu_types_pkg.sv
// Shared CPU types: branch-predictor counter encoding, table entry layout and
// the tag-extraction helper used by both lookup and update paths.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } bp_cnt_t;

  // Sized for the smallest legal table (2 entries); larger tables zero-extend.
  localparam int BP_TAG_W = 29;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [29:0]         target;
    bp_cnt_t             cnt;
  } bp_entry_t;

  localparam bp_cnt_t BP_ALLOC_CNT = WT;

  localparam bp_entry_t BP_RESET_ENTRY = '{valid: 1'b0, tag: '0, target: '0, cnt: WNT};

  // Word-address PC [31:2] -> tag bits [31:idxw+2], right-aligned.
  function automatic logic [BP_TAG_W-1:0] bp_tag(input logic [29:0] pc_w, input int idxw);
    return BP_TAG_W'(pc_w >> idxw);
  endfunction

endpackage

// File: rtl/bp_if.sv
// Predictor <-> PC/pipeline signal bundle; `bp` is the predictor side, `pc`
// the side that drives fetch PCs and resolved-branch updates.
interface bp_if;
  logic [31:2] cpc;
  logic        bpSel;
  logic [29:0] bp_a;
  logic        upd_en;
  logic [31:2] upd_pc;
  logic        upd_taken;
  logic [29:0] upd_target;
  logic        upd_pred;
  logic [29:0] upd_pred_a;
  logic        bpFlush;
  logic [31:0] stat_br;
  logic [31:0] stat_miss;

  modport bp (
    input  cpc, upd_en, upd_pc, upd_taken, upd_target, upd_pred, upd_pred_a,
    output bpSel, bp_a, bpFlush, stat_br, stat_miss
  );

  modport pc (
    output cpc, upd_en, upd_pc, upd_taken, upd_target, upd_pred, upd_pred_a,
    input  bpSel, bp_a, bpFlush, stat_br, stat_miss
  );
endinterface

// File: rtl/bp_sat_counter.sv
// 2-bit saturating direction counter next-state function.
module bp_sat_counter
  import cpu_types_pkg::*;
(
  input  bp_cnt_t i_cnt,
  input  logic    i_taken,
  output bp_cnt_t o_cnt
);

  always_comb begin
    // NOTE: default first so every path assigns o_cnt and no latch is inferred.
    o_cnt = i_cnt;
    case (i_cnt)
      SNT: o_cnt = i_taken ? WNT : SNT;
      WNT: o_cnt = i_taken ? WT  : SNT;
      WT:  o_cnt = i_taken ? ST  : WNT;
      ST:  o_cnt = i_taken ? ST  : WT;
    endcase
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit direction counters: combinational lookup of the
// fetch PC, edge-triggered update from resolved branches, flush and statistics.
module branch_predictor
  import cpu_types_pkg::*;
#(
  parameter int NENTRIES = 8
) (
  input  logic CLK,
  input  logic RST,
  bp_if.bp     bus
);

  localparam int IDXW = $clog2(NENTRIES);

  bp_entry_t r_table [NENTRIES];
  logic [31:0] r_stat_br;
  logic [31:0] r_stat_miss;

  logic [IDXW-1:0]     w_lk_idx;
  logic [BP_TAG_W-1:0] w_lk_tag;
  bp_entry_t           w_lk_entry;
  logic                w_lk_hit;

  logic [IDXW-1:0]     w_upd_idx;
  logic [BP_TAG_W-1:0] w_upd_tag;
  bp_entry_t           w_upd_entry;
  logic                w_upd_hit;
  bp_cnt_t             w_next_cnt;
  logic                w_flush;

  // Lookup reads the registered table only, so a same-cycle update is not bypassed.
  assign w_lk_idx   = bus.cpc[IDXW+1:2];
  assign w_lk_tag   = bp_tag(bus.cpc, IDXW);
  assign w_lk_entry = r_table[w_lk_idx];
  assign w_lk_hit   = w_lk_entry.valid && (w_lk_entry.tag == w_lk_tag);

  assign bus.bpSel = w_lk_hit & w_lk_entry.cnt[1];
  assign bus.bp_a  = w_lk_hit ? w_lk_entry.target : 30'd0;

  assign w_upd_idx   = bus.upd_pc[IDXW+1:2];
  assign w_upd_tag   = bp_tag(bus.upd_pc, IDXW);
  assign w_upd_entry = r_table[w_upd_idx];
  assign w_upd_hit   = w_upd_entry.valid && (w_upd_entry.tag == w_upd_tag);

  bp_sat_counter u_sat_counter (
    .i_cnt   (w_upd_entry.cnt),
    .i_taken (bus.upd_taken),
    .o_cnt   (w_next_cnt)
  );

  // Wrong direction, or taken as predicted but to a different target.
  assign w_flush = !RST && bus.upd_en &&
                   ((bus.upd_pred != bus.upd_taken) ||
                    (bus.upd_pred && bus.upd_taken && (bus.upd_pred_a != bus.upd_target)));

  assign bus.bpFlush   = w_flush;
  assign bus.stat_br   = r_stat_br;
  assign bus.stat_miss = r_stat_miss;

  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: the table is reset entry by entry because post-reset lookups must
      // miss; this keeps it in flops rather than a RAM macro, fine at <= 64 entries.
      for (int i = 0; i < NENTRIES; i++) begin
        r_table[i] <= BP_RESET_ENTRY;
      end
      r_stat_br   <= '0;
      r_stat_miss <= '0;
    end else if (bus.upd_en) begin
      // NOTE: non-blocking updates so every read this cycle sees pre-edge state.
      r_stat_br   <= r_stat_br + 32'd1;
      r_stat_miss <= r_stat_miss + 32'(w_flush);
      if (w_upd_hit) begin
        r_table[w_upd_idx].cnt <= w_next_cnt;
        if (bus.upd_taken) begin
          r_table[w_upd_idx].target <= bus.upd_target;
        end
      end else if (bus.upd_taken) begin
        r_table[w_upd_idx] <= '{valid:  1'b1,
                                tag:    w_upd_tag,
                                target: bus.upd_target,
                                cnt:    BP_ALLOC_CNT};
      end
    end
  end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Direct-mapped branch target buffer with 2-bit saturating direction counters, sitting directly upstream of the program counter stage. Each cycle it looks up the current fetch PC and drives `bpSel`/`bp_a` into the PC stage. When a branch resolves in the pipeline it updates the table, raises `bpFlush` on a misprediction, and maintains branch and mispredict statistics.

## Interface
- `NENTRIES`, 8 — table depth; power of two, 2..64.
- `IDXW`, $clog2(NENTRIES) — index width (derived).
- `CLK` in 1 — clock.
- `RST` in 1 — reset, synchronous, active-high.
- `cpc` in [31:2] — current fetch PC (word address).
- `bpSel` out 1 — predict taken; PC stage selects `bp_a`.
- `bp_a` out [29:0] — predicted target (word address).
- `upd_en` in 1 — a conditional branch resolves this cycle.
- `upd_pc` in [31:2] — PC of the resolving branch.
- `upd_taken` in 1 — actual direction.
- `upd_target` in [29:0] — actual taken target.
- `upd_pred` in 1 — `bpSel` value carried down the pipe with this branch.
- `upd_pred_a` in [29:0] — `bp_a` value carried down the pipe.
- `bpFlush` out 1 — misprediction; PC stage redirects and the pipe flushes.
- `stat_br` out 32 — resolved-branch count.
- `stat_miss` out 32 — misprediction count.

## Operation
- Entry fields: `valid`, `tag` [31:IDXW+2], `target` [29:0], and `cnt` (2-bit: SNT=00, WNT=01, WT=10, ST=11).
- Index is `pc[IDXW+1:2]`; tag is `pc[31:IDXW+2]`.
- Lookup is combinational.
  - hit = `valid` and tag matches.
  - `bpSel` = hit & `cnt[1]`.
  - `bp_a` = entry target when hit, else 0.
- `bpFlush` is combinational: `upd_en & ((upd_pred != upd_taken) | (upd_pred & upd_taken & (upd_pred_a != upd_target)))`.
- Update occurs on the clock edge with `upd_en`, indexed by `upd_pc`.
  - Hit, taken: `cnt` saturating increment; `target` <= `upd_target`.
  - Hit, not taken: `cnt` saturating decrement; target unchanged.
  - Miss, taken: allocate and overwrite the entry: `valid`=1, tag, target, `cnt`=WT.
  - Miss, not taken: no table change.
- Statistics, evaluated each `upd_en` cycle:
  - `stat_br` += 1.
  - `stat_miss` += `bpFlush`.
  - Both are 32-bit and wrap modulo 2^32.
- Jumps and `jr` are not handled; the PC stage resolves them. `upd_en` is asserted for conditional branches only.

## Timing
- Lookup latency is 0 cycles; outputs depend only on `cpc` and the current table state.
- Update becomes visible to lookup on the cycle after the `upd_en` edge.
- Simultaneous lookup and update of the same index: lookup returns the pre-update contents, with no bypass.
- `upd_en` is honoured regardless of any PC-stage stall; the predictor has no enable.
- Reset, synchronous: all `valid`=0, all `cnt`=WNT, targets=0, stats=0.
  - Post-reset outputs: `bpSel`=0, `bp_a`=0.
  - `bpFlush` is forced to 0 in any cycle with `RST`=1.
- `RST` asserted in a cycle with `upd_en`: reset wins; no update and no stat increment.
- Aliasing: a different tag on the same index overwrites only on a taken miss. A not-taken alias leaves the resident entry untouched.

## Structure
- Add to `cpu_types_pkg`:
  - `bp_cnt_t` enum {SNT, WNT, WT, ST}.
  - `bp_entry_t` packed struct {valid, tag, target, cnt}.
  - Constant `BP_ALLOC_CNT` = WT.
- Add interface `bp_if` with modport `bp` (ports above, excluding `CLK`/`RST`).
- One sub-module: `bp_sat_counter`, a combinational 2-bit next-state function (inputs `cnt`, `taken`; output next `cnt`), instantiated once on the update path.

## Test plan
- Reset, then `cpc`=0x100 → `bpSel`=0, `bp_a`=0.
- Resolve taken branch `upd_pc`=0x100, `upd_target`=0x200, `upd_pred`=0 → `bpFlush`=1 in that cycle. Next cycle with `cpc`=0x100 → `bpSel`=1, `bp_a`=0x200; `stat_br`=1, `stat_miss`=1.
- Counter saturation:
  - Same branch resolved taken 3 more times → `cnt`=ST.
  - Then not taken twice → WT, then WNT; `bpSel`=0 only after the second.
  - Then taken once → WT, `bpSel`=1.
- Alias, with `NENTRIES`=8:
  - Taken `upd_pc`=0x120 (same index as 0x100) → entry replaced; `cpc`=0x100 → `bpSel`=0.
  - Not-taken at 0x140 → 0x120 entry kept.
- Target mismatch: `upd_pred`=1, `upd_taken`=1, `upd_pred_a`=0x200, `upd_target`=0x300 → `bpFlush`=1; next lookup `bp_a`=0x300.
- Same-cycle conflict: lookup 0x100 while updating 0x100 not-taken from WT → lookup shows `bpSel`=1 that cycle, 0 the next.
- Reset asserted with `upd_en`=1 → stats remain 0 and `bpFlush`=0.
